// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller.
//   Accepts 25p/50p/100p coins up to MAXCREDIT, vends one of four products
//   priced by PRICE0..PRICE3, pays change after a vend, and refunds credit on
//   cancel or after TIMEOUT idle cycles while collecting.
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous, active-low
//   coin[1:0]    - 00=25p, 01=50p, 10=100p, 11=no coin
//   sel[1:0]     - product index, sampled with sel_valid
//   sel_valid    - one-cycle product request
//   cancel       - refund request (honoured only while collecting)
//   change_ack   - dispenser has paid out change_amt
//   credit[7:0]  - accumulated credit in paise
//   vend         - one-cycle product release pulse, prod_id valid with it
//   change_valid - change/refund request, change_amt held while high
//   coin_reject  - one-cycle pulse: the coin offered last cycle was refused
//   low_credit   - one-cycle pulse: selection refused for insufficient credit
//   busy         - high while vending, paying change or refunding
module vend_ctrl #(
  parameter logic [7:0] PRICE0    = 8'd25,
  parameter logic [7:0] PRICE1    = 8'd50,
  parameter logic [7:0] PRICE2    = 8'd75,
  parameter logic [7:0] PRICE3    = 8'd100,
  parameter logic [7:0] TIMEOUT   = 8'd200,
  parameter logic [7:0] MAXCREDIT = 8'd200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic [1:0] sel,
  input  logic       sel_valid,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [7:0] credit,
  output logic       vend,
  output logic [1:0] prod_id,
  output logic       change_valid,
  output logic [7:0] change_amt,
  output logic       coin_reject,
  output logic       low_credit,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, REFUND} state_t;

  state_t     state, state_nx;
  logic [7:0] idle_cnt, idle_cnt_nx;
  logic [7:0] credit_nx;
  logic [1:0] sel_lat, sel_lat_nx;
  logic       reject_nx, low_nx;
  logic       coin_ok;
  logic [7:0] coin_val;
  logic [7:0] price;
  logic [8:0] sum;
  logic       paying_nx;

  always_comb begin
    coin_ok  = 1'b1;
    coin_val = '0;
    case (coin)
      2'b00:   coin_val = 8'd25;
      2'b01:   coin_val = 8'd50;
      2'b10:   coin_val = 8'd100;
      default: coin_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (sel)
      2'd0:    price = PRICE0;
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      default: price = PRICE3;
    endcase
  end

  // 9-bit sum so the ceiling test cannot be fooled by 8-bit wrap.
  assign sum = {1'b0, credit} + {1'b0, coin_val};

  always_comb begin
    state_nx    = state;
    credit_nx   = credit;
    idle_cnt_nx = idle_cnt;
    sel_lat_nx  = sel_lat;
    reject_nx   = 1'b0;
    low_nx      = 1'b0;
    case (state)
      IDLE: begin
        credit_nx = '0;
        if (coin_ok) begin
          if (sum <= {1'b0, MAXCREDIT}) begin
            credit_nx   = coin_val;
            state_nx    = COLLECT;
            idle_cnt_nx = '0;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end
      COLLECT: begin
        // cancel beats sel_valid beats coin; a coin losing priority is refused
        if (cancel) begin
          state_nx    = REFUND;
          reject_nx   = coin_ok;
          idle_cnt_nx = '0;
        end else if (sel_valid) begin
          idle_cnt_nx = '0;
          reject_nx   = coin_ok;
          if (credit >= price) begin
            credit_nx  = credit - price;
            sel_lat_nx = sel;
            state_nx   = VEND;
          end else begin
            low_nx = 1'b1;
          end
        end else if (coin_ok) begin
          idle_cnt_nx = '0;
          if (sum <= {1'b0, MAXCREDIT}) credit_nx = sum[7:0];
          else                          reject_nx = 1'b1;
        end else if (idle_cnt == TIMEOUT - 8'd1) begin
          state_nx    = REFUND;
          idle_cnt_nx = '0;
        end else begin
          idle_cnt_nx = idle_cnt + 8'd1;
        end
      end
      VEND: begin
        reject_nx = coin_ok;
        state_nx  = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE, REFUND: begin
        reject_nx = coin_ok;
        if (change_ack) begin
          credit_nx = '0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign paying_nx = (state_nx == CHANGE) || (state_nx == REFUND);

  // Outputs are registered from next-state values so they line up with the
  // state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idle_cnt     <= '0;
      sel_lat      <= '0;
      credit       <= '0;
      vend         <= 1'b0;
      prod_id      <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      low_credit   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      idle_cnt     <= idle_cnt_nx;
      sel_lat      <= sel_lat_nx;
      credit       <= credit_nx;
      vend         <= (state_nx == VEND);
      prod_id      <= (state_nx == VEND) ? sel_lat_nx : '0;
      change_valid <= paying_nx;
      change_amt   <= paying_nx ? credit_nx : '0;
      coin_reject  <= reject_nx;
      low_credit   <= low_nx;
      busy         <= (state_nx == VEND) || paying_nx;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed testbench for vend_ctrl with a transaction-level
// reference model; outputs are compared on every falling edge.
module tb_vend_ctrl;

  localparam int TMO  = 200;
  localparam int MAXC = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       sel_valid;
  logic       cancel;
  logic       change_ack;
  logic [7:0] credit;
  logic       vend;
  logic [1:0] prod_id;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject;
  logic       low_credit;
  logic       busy;

  int total = 0;
  int bad   = 0;

  vend_ctrl #(
    .PRICE0(8'd25), .PRICE1(8'd50), .PRICE2(8'd75), .PRICE3(8'd100),
    .TIMEOUT(8'd200), .MAXCREDIT(8'd200)
  ) dut (
    .clock(clock), .reset(reset), .coin(coin), .sel(sel),
    .sel_valid(sel_valid), .cancel(cancel), .change_ack(change_ack),
    .credit(credit), .vend(vend), .prod_id(prod_id),
    .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .low_credit(low_credit), .busy(busy)
  );

  always #5 clock = ~clock;

  // Model: customer session phase plus credit ledger.
  localparam int P_IDLE = 0, P_COLLECT = 1, P_VEND = 2, P_PAY = 3;
  int price_tab [4] = '{25, 50, 75, 100};
  int m_phase = P_IDLE, m_credit = 0, m_idle = 0, m_prod = 0;
  int e_credit = 0, e_vend = 0, e_prod = 0, e_cv = 0, e_amt = 0;
  int e_rej = 0, e_low = 0, e_busy = 0;

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b00:   return 25;
      2'b01:   return 50;
      2'b10:   return 100;
      default: return 0;
    endcase
  endfunction

  // Predict outputs after the coming rising edge from the inputs now applied.
  task automatic model_step();
    int v;
    v = coin_value(coin);
    e_rej = 0;
    e_low = 0;
    if (!reset) begin
      m_phase = P_IDLE; m_credit = 0; m_idle = 0; m_prod = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (v > 0) begin
          if (v <= MAXC) begin m_credit = v; m_phase = P_COLLECT; m_idle = 0; end
          else e_rej = 1;
        end
        P_COLLECT: begin
          if (cancel) begin
            m_phase = P_PAY; e_rej = (v > 0) ? 1 : 0;
          end else if (sel_valid) begin
            m_idle = 0; e_rej = (v > 0) ? 1 : 0;
            if (m_credit >= price_tab[sel]) begin
              m_credit = m_credit - price_tab[sel]; m_prod = int'(sel); m_phase = P_VEND;
            end else e_low = 1;
          end else if (v > 0) begin
            m_idle = 0;
            if (m_credit + v <= MAXC) m_credit = m_credit + v; else e_rej = 1;
          end else begin
            m_idle++;
            if (m_idle >= TMO) m_phase = P_PAY;
          end
        end
        P_VEND: begin
          e_rej = (v > 0) ? 1 : 0;
          m_phase = (m_credit > 0) ? P_PAY : P_IDLE;
        end
        default: begin
          e_rej = (v > 0) ? 1 : 0;
          if (change_ack) begin m_credit = 0; m_phase = P_IDLE; end
        end
      endcase
    end
    e_credit = m_credit;
    e_vend   = (m_phase == P_VEND) ? 1 : 0;
    e_prod   = e_vend ? m_prod : 0;
    e_cv     = (m_phase == P_PAY) ? 1 : 0;
    e_amt    = e_cv ? m_credit : 0;
    e_busy   = (m_phase >= P_VEND) ? 1 : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("credit", credit, e_credit);
    chk("vend", vend, e_vend);
    if (e_vend != 0 || !reset) chk("prod_id", prod_id, e_prod);
    chk("change_valid", change_valid, e_cv);
    if (e_cv != 0 || !reset) chk("change_amt", change_amt, e_amt);
    chk("coin_reject", coin_reject, e_rej);
    chk("low_credit", low_credit, e_low);
    chk("busy", busy, e_busy);
  endtask

  // Apply inputs at a falling edge, step the model, check at the next falling edge.
  task automatic tick(input logic [1:0] c, input logic [1:0] s, input logic sv,
                      input logic cn, input logic ak);
    coin = c; sel = s; sel_valid = sv; cancel = cn; change_ack = ak;
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic idle_tick();        tick(2'b11, 2'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic put(input logic [1:0] c); tick(c, 2'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic pick(input logic [1:0] s); tick(2'b11, s, 1'b1, 1'b0, 1'b0); endtask
  task automatic ack();              tick(2'b11, 2'd0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    coin = 2'b11; sel = '0; sel_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0;
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_credit", credit, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cv", change_valid, 0);
    idle_tick();
    idle_tick();
    reset = 1'b1;

    // IDLE ignores selection, cancel and stray ack
    tick(2'b11, 2'd2, 1'b1, 1'b1, 1'b1);
    chk("idle_ignore_vend", vend, 0);

    // four 25p coins then product 3
    put(2'b00); chk("s40_c25", credit, 25);
    put(2'b00); chk("s40_c50", credit, 50);
    put(2'b00); chk("s40_c75", credit, 75);
    put(2'b00); chk("s40_c100", credit, 100);
    pick(2'd3);
    chk("s40_vend", vend, 1);
    chk("s40_prod", prod_id, 3);
    chk("s40_credit0", credit, 0);
    idle_tick();
    chk("s40_idle_busy", busy, 0);
    chk("s40_no_change", change_valid, 0);

    // 100p, product 1, change 50 held until ack; coin during payout refused
    put(2'b10); chk("s41_c100", credit, 100);
    pick(2'd1);
    chk("s41_vend", vend, 1);
    chk("s41_prod", prod_id, 1);
    put(2'b01);
    chk("s41_cv", change_valid, 1);
    chk("s41_amt", change_amt, 50);
    chk("s41_vend_coin_rej", coin_reject, 1);
    put(2'b00);
    chk("s41_change_coin_rej", coin_reject, 1);
    chk("s41_amt_hold", change_amt, 50);
    idle_tick();
    ack();
    chk("s41_cv_off", change_valid, 0);
    chk("s41_credit0", credit, 0);

    // credit ceiling
    put(2'b10); put(2'b10);
    chk("s42_c200", credit, 200);
    put(2'b00);
    chk("s42_reject", coin_reject, 1);
    chk("s42_hold200", credit, 200);
    pick(2'd0);
    chk("s42_vend", vend, 1);
    chk("s42_c175", credit, 175);
    idle_tick();
    chk("s42_amt", change_amt, 175);
    ack();

    // low credit, ignored ack in COLLECT, cancel beating a coin
    put(2'b01);
    pick(2'd3);
    chk("s43_low", low_credit, 1);
    chk("s43_busy", busy, 0);
    ack();
    chk("s43_ack_ignored", credit, 50);
    tick(2'b00, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("s43_rej", coin_reject, 1);
    chk("s43_cv", change_valid, 1);
    chk("s43_amt", change_amt, 50);
    ack();

    // selection and coin together: selection wins, coin refused
    put(2'b10);
    tick(2'b01, 2'd2, 1'b1, 1'b0, 1'b0);
    chk("sel_coin_rej", coin_reject, 1);
    chk("sel_coin_c25", credit, 25);
    idle_tick();
    ack();

    // timeout refund, delayed ack
    put(2'b00);
    repeat (TMO - 1) idle_tick();
    chk("s44_not_yet", change_valid, 0);
    idle_tick();
    chk("s44_cv", change_valid, 1);
    chk("s44_amt", change_amt, 25);
    for (int i = 0; i < 4; i++) begin
      idle_tick();
      chk("s44_hold", change_valid, 1);
    end
    ack();
    chk("s44_done", change_valid, 0);

    // asynchronous reset mid-CHANGE
    put(2'b10);
    pick(2'd0);
    idle_tick();
    chk("s45_cv_before", change_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("s45_cv_now", change_valid, 0);
    chk("s45_amt_now", change_amt, 0);
    chk("s45_credit_now", credit, 0);
    chk("s45_busy_now", busy, 0);
    @(negedge clock);
    idle_tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_tick();
      chk("s45_after_cv", change_valid, 0);
      chk("s45_after_vend", vend, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
